// File: rtl/multi_channel_monitor_fifo.sv
// Per-channel (address, data) capture FIFOs drained through one Avalon-MM read slave, with AF/OVF interrupts.
// Optional per-channel saturating drop counters: define MONITOR_FIFO_DROP_CNT_EN.
module multi_channel_monitor_fifo #(
   parameter int unsigned NUM_CHANNELS      = 2,
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned ADDRESS_WIDTH     = 10,
   parameter int unsigned CSR_ADDRESS_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH        = 64,
   parameter int unsigned ALMOST_FULL       = 56
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [NUM_CHANNELS-1:0]               avs_in_write,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    avs_in_writedata,
   input  logic [NUM_CHANNELS*ADDRESS_WIDTH-1:0] avs_in_address,
   output logic                                  avs_in_waitrequest,
   input  logic                                  avs_out_read,
   input  logic [ADDRESS_WIDTH-1:0]              avs_out_address,
   output logic [DATA_WIDTH-1:0]                 avs_out_readdata,
   output logic                                  avs_out_waitrequest,
   output logic [NUM_CHANNELS-1:0]               empty,
   output logic                                  irq,
   input  logic [CSR_ADDRESS_WIDTH-1:0]          csr_address,
   input  logic                                  csr_read,
   input  logic                                  csr_write,
   input  logic [DATA_WIDTH-1:0]                 csr_writedata,
   output logic [DATA_WIDTH-1:0]                 csr_readdata
);

   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int unsigned PEND_W = 2 * NUM_CHANNELS;
   localparam int unsigned DROP_W = 12;

   typedef struct packed {
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0]    data;
   } rec_t;

   rec_t                    mem_q [NUM_CHANNELS][FIFO_DEPTH];
   rec_t                    in_rec [NUM_CHANNELS];
   logic [PTR_W-1:0]        head_q [NUM_CHANNELS];
   logic [PTR_W-1:0]        head_d [NUM_CHANNELS];
   logic [PTR_W-1:0]        tail_q [NUM_CHANNELS];
   logic [PTR_W-1:0]        tail_d [NUM_CHANNELS];
   logic [CNT_W-1:0]        count_q [NUM_CHANNELS];
   logic [CNT_W-1:0]        count_d [NUM_CHANNELS];
   logic [DROP_W-1:0]       drop_v [NUM_CHANNELS];
   logic [CNT_W-1:0]        thresh_q, thresh_d;
   logic [PEND_W-1:0]       pend_q, pend_d, en_q, en_d, pend_clr, pend_set;
   logic [NUM_CHANNELS-1:0] af_prev_q, af_prev_d, empty_q, empty_d;
   logic                    wait_q, wait_d, irq_q, irq_d;
   logic [NUM_CHANNELS-1:0] full_c, empty_c, af_c, pop_c, push_ok_c, reject_c;
   logic [CH_W-1:0]         sel_c;
   logic                    unused_c;

   assign avs_in_waitrequest  = 1'b0;
   assign avs_out_waitrequest = wait_q;
   assign empty               = empty_q;
   assign irq                 = irq_q;
   assign sel_c               = avs_out_address[CH_W:1];
   assign unused_c            = ^{csr_read, csr_writedata, avs_out_address};

   // Queue bookkeeping: a pop frees a slot for a same-cycle push on a full channel.
   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      empty_d   = empty_q;
      af_prev_d = af_prev_q;
      full_c    = '0;
      empty_c   = '0;
      af_c      = '0;
      pop_c     = '0;
      push_ok_c = '0;
      reject_c  = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         in_rec[c].addr = avs_in_address[c*ADDRESS_WIDTH +: ADDRESS_WIDTH];
         in_rec[c].data = avs_in_writedata[c*DATA_WIDTH +: DATA_WIDTH];
         full_c[c]    = (count_q[c] == CNT_W'(FIFO_DEPTH));
         empty_c[c]   = (count_q[c] == '0);
         af_c[c]      = (count_q[c] >= thresh_q);
         pop_c[c]     = avs_out_read && avs_out_address[0] && !wait_q
                        && (sel_c == CH_W'(c)) && !empty_c[c];
         push_ok_c[c] = avs_in_write[c] && (!full_c[c] || pop_c[c]);
         reject_c[c]  = avs_in_write[c] && !push_ok_c[c];
         head_d[c]    = head_q[c] + PTR_W'(pop_c[c]);
         tail_d[c]    = tail_q[c] + PTR_W'(push_ok_c[c]);
         count_d[c]   = count_q[c] + CNT_W'(push_ok_c[c]) - CNT_W'(pop_c[c]);
         empty_d[c]   = (count_d[c] == '0);
         af_prev_d[c] = af_c[c];
      end
   end

   // CSR writes, pending flags (set beats W1C), interrupt and read wait state.
   always_comb begin
      thresh_d = thresh_q;
      en_d     = en_q;
      pend_clr = '0;
      if (csr_write) begin
         if (csr_address == CSR_ADDRESS_WIDTH'(0)) pend_clr = csr_writedata[PEND_W-1:0];
         if (csr_address == CSR_ADDRESS_WIDTH'(1)) en_d = csr_writedata[PEND_W-1:0];
         if (csr_address == CSR_ADDRESS_WIDTH'(2)) thresh_d = csr_writedata[CNT_W-1:0];
      end
      pend_set = {reject_c, af_c & ~af_prev_q};
      pend_d   = (pend_q & ~pend_clr) | pend_set;
      irq_d    = |(pend_q & en_q);
      wait_d   = !(avs_out_read && wait_q);
   end

`ifdef MONITOR_FIFO_DROP_CNT_EN
   logic [DROP_W-1:0] drop_q [NUM_CHANNELS];
   logic [DROP_W-1:0] drop_d [NUM_CHANNELS];

   // Saturating rejected-push counters; any STATUS write clears before counting.
   always_comb begin
      drop_d = drop_q;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (csr_write && (csr_address == CSR_ADDRESS_WIDTH'(16 + c))) drop_d[c] = '0;
         if (reject_c[c] && (drop_d[c] != '1)) drop_d[c] = drop_d[c] + DROP_W'(1);
         drop_v[c] = drop_q[c];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) drop_q[c] <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end
`else
   always_comb begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) drop_v[c] = '0;
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            head_q[c]  <= '0;
            tail_q[c]  <= '0;
            count_q[c] <= '0;
         end
         thresh_q  <= CNT_W'(ALMOST_FULL);
         pend_q    <= '0;
         en_q      <= '1;
         af_prev_q <= '0;
         empty_q   <= '1;
         wait_q    <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         thresh_q  <= thresh_d;
         pend_q    <= pend_d;
         en_q      <= en_d;
         af_prev_q <= af_prev_d;
         empty_q   <= empty_d;
         wait_q    <= wait_d;
         irq_q     <= irq_d;
      end
   end

   // Storage array carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (push_ok_c[c]) mem_q[c][tail_q[c]] <= in_rec[c];
      end
   end

   always_comb begin
      avs_out_readdata = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if ((sel_c == CH_W'(c)) && !empty_c[c]) begin
            avs_out_readdata = avs_out_address[0] ? mem_q[c][head_q[c]].data
                                                  : DATA_WIDTH'(mem_q[c][head_q[c]].addr);
         end
      end
   end

   always_comb begin
      logic [31:0] st;
      csr_readdata = '0;
      st           = '0;
      if (csr_address == CSR_ADDRESS_WIDTH'(0)) csr_readdata = DATA_WIDTH'(pend_q);
      if (csr_address == CSR_ADDRESS_WIDTH'(1)) csr_readdata = DATA_WIDTH'(en_q);
      if (csr_address == CSR_ADDRESS_WIDTH'(2)) csr_readdata = DATA_WIDTH'(thresh_q);
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (csr_address == CSR_ADDRESS_WIDTH'(16 + c)) begin
            st              = '0;
            st[31]          = af_c[c];
            st[30]          = empty_c[c];
            st[29]          = full_c[c];
            st[27:16]       = drop_v[c];
            st[CNT_W-1:0]   = count_q[c];
            csr_readdata    = DATA_WIDTH'(st);
         end
      end
   end

endmodule

// File: tb/tb_multi_channel_monitor_fifo.sv
// Directed self-checking bench for multi_channel_monitor_fifo (2 channels, depth 64).
module tb_multi_channel_monitor_fifo;

   localparam int unsigned NC = 2;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;

`ifdef MONITOR_FIFO_DROP_CNT_EN
   localparam logic [31:0] DROP3 = 32'h0003_0000;
   localparam logic [31:0] DROP1 = 32'h0001_0000;
`else
   localparam logic [31:0] DROP3 = 32'h0;
   localparam logic [31:0] DROP1 = 32'h0;
`endif

   logic             clk;
   logic             reset_n;
   logic [NC-1:0]    avs_in_write;
   logic [NC*DW-1:0] avs_in_writedata;
   logic [NC*AW-1:0] avs_in_address;
   logic             avs_in_waitrequest;
   logic             avs_out_read;
   logic [AW-1:0]    avs_out_address;
   logic [DW-1:0]    avs_out_readdata;
   logic             avs_out_waitrequest;
   logic [NC-1:0]    empty;
   logic             irq;
   logic [4:0]       csr_address;
   logic             csr_read;
   logic             csr_write;
   logic [DW-1:0]    csr_writedata;
   logic [DW-1:0]    csr_readdata;

   int checks   = 0;
   int failures = 0;
   logic [31:0] v;

   multi_channel_monitor_fifo dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .avs_in_write        (avs_in_write),
      .avs_in_writedata    (avs_in_writedata),
      .avs_in_address      (avs_in_address),
      .avs_in_waitrequest  (avs_in_waitrequest),
      .avs_out_read        (avs_out_read),
      .avs_out_address     (avs_out_address),
      .avs_out_readdata    (avs_out_readdata),
      .avs_out_waitrequest (avs_out_waitrequest),
      .empty               (empty),
      .irq                 (irq),
      .csr_address         (csr_address),
      .csr_read            (csr_read),
      .csr_write           (csr_write),
      .csr_writedata       (csr_writedata),
      .csr_readdata        (csr_readdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic csr_rd(input logic [4:0] a, output logic [31:0] d);
      csr_address = a;
      csr_read    = 1'b1;
      #1;
      d        = csr_readdata;
      csr_read = 1'b0;
   endtask

   task automatic csr_wr(input logic [4:0] a, input logic [31:0] d);
      csr_address   = a;
      csr_writedata = d;
      csr_write     = 1'b1;
      @(negedge clk);
      csr_write     = 1'b0;
   endtask

   task automatic push(input int ch, input logic [9:0] a, input logic [31:0] d);
      avs_in_write[ch]              = 1'b1;
      avs_in_address[ch*AW +: AW]   = a;
      avs_in_writedata[ch*DW +: DW] = d;
      @(negedge clk);
      avs_in_write = '0;
   endtask

   task automatic rd(input int ch, input bit p, output logic [31:0] d);
      avs_out_read    = 1'b1;
      avs_out_address = AW'(ch * 2 + int'(p));
      @(negedge clk);
      d = avs_out_readdata;
      @(negedge clk);
      avs_out_read = 1'b0;
   endtask

   initial begin
      reset_n          = 1'b1;
      avs_in_write     = '0;
      avs_in_writedata = '0;
      avs_in_address   = '0;
      avs_out_read     = 1'b0;
      avs_out_address  = '0;
      csr_address      = '0;
      csr_read         = 1'b0;
      csr_write        = 1'b0;
      csr_writedata    = '0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_wait", 32'(avs_out_waitrequest), 32'h1);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_empty", 32'(empty), 32'h3);
      csr_rd(5'd2, v);  check("rst_thresh", v, 32'd56);
      csr_rd(5'd1, v);  check("rst_irq_en", v, 32'hF);
      csr_rd(5'd16, v); check("rst_status0", v, 32'h4000_0000);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // FIFO order on two channels
      for (int i = 0; i < 3; i++) push(0, 10'(32'h100 + i), 32'hA0 + i);
      for (int i = 0; i < 2; i++) push(1, 10'(32'h200 + i), 32'hB0 + i);
      check("empty_after_push", 32'(empty), 32'h0);
      csr_rd(5'd16, v); check("status0_cnt3", v, 32'h0000_0003);
      csr_rd(5'd17, v); check("status1_cnt2", v, 32'h0000_0002);
      check("idle_wait", 32'(avs_out_waitrequest), 32'h1);
      avs_out_read    = 1'b1;
      avs_out_address = AW'(0);
      @(negedge clk);
      check("wait_n1", 32'(avs_out_waitrequest), 32'h0);
      check("addr_field_ch0", avs_out_readdata, 32'h100);
      @(negedge clk);
      avs_out_read = 1'b0;
      check("wait_n2", 32'(avs_out_waitrequest), 32'h1);
      csr_rd(5'd16, v); check("addr_read_no_pop", v, 32'h0000_0003);
      for (int i = 0; i < 3; i++) begin rd(0, 1'b1, v); check("pop_ch0", v, 32'hA0 + i); end
      for (int i = 0; i < 2; i++) begin rd(1, 1'b1, v); check("pop_ch1", v, 32'hB0 + i); end
      check("empty_after_pop", 32'(empty), 32'h3);
      rd(0, 1'b0, v); check("addr_read_empty", v, 32'h0);
      rd(1, 1'b1, v); check("data_read_empty", v, 32'h0);

      // Overflow on ch0
      for (int i = 0; i < 64; i++) push(0, 10'(i), 32'hC000_0000 + i);
      for (int i = 0; i < 3; i++) push(0, 10'h3FF, 32'hDEAD_0000 + i);
      @(negedge clk);
      csr_rd(5'd16, v); check("status0_full", v, 32'hA000_0040 | DROP3);
      check("empty_full", 32'(empty), 32'h2);
      csr_rd(5'd0, v);  check("pend_ovf0_af0", v, 32'h5);
      check("irq_ovf", 32'(irq), 32'h1);

      // Push and pop on full ch0 in the same cycle
      csr_wr(5'd0, 32'hF);
      @(negedge clk);
      avs_out_read    = 1'b1;
      avs_out_address = AW'(1);
      @(negedge clk);
      check("full_pop_data", avs_out_readdata, 32'hC000_0000);
      avs_in_write[0]         = 1'b1;
      avs_in_address[0 +: AW] = 10'h2AA;
      avs_in_writedata[0 +: DW] = 32'h999;
      @(negedge clk);
      avs_out_read = 1'b0;
      avs_in_write = '0;
      csr_rd(5'd16, v); check("status0_still_full", v, 32'hA000_0040 | DROP3);
      csr_rd(5'd0, v);  check("pend_no_ovf", v, 32'h0);
      @(negedge clk);
      check("irq_cleared", 32'(irq), 32'h0);
      rd(0, 1'b0, v); check("head_addr", v, 32'h1);
      for (int i = 1; i < 64; i++) begin rd(0, 1'b1, v); check("drain", v, 32'hC000_0000 + i); end
      rd(0, 1'b1, v); check("drain_last", v, 32'h999);
      check("empty_drained", 32'(empty), 32'h3);

      // Run-time threshold and almost-full edge
      csr_wr(5'd2, 32'd4);
      csr_rd(5'd2, v); check("thresh_rb", v, 32'd4);
      for (int i = 0; i < 4; i++) push(0, 10'(i), 32'h50 + i);
      csr_rd(5'd0, v); check("af_pend_edge0", v, 32'h0);
      check("af_irq_edge0", 32'(irq), 32'h0);
      @(negedge clk);
      csr_rd(5'd0, v); check("af_pend_edge1", v, 32'h1);
      check("af_irq_edge1", 32'(irq), 32'h0);
      @(negedge clk);
      check("af_irq_edge2", 32'(irq), 32'h1);
      csr_wr(5'd0, 32'h1);
      csr_rd(5'd0, v); check("af_w1c", v, 32'h0);
      @(negedge clk);
      check("af_irq_fall", 32'(irq), 32'h0);
      push(0, 10'd4, 32'h54);
      @(negedge clk);
      @(negedge clk);
      csr_rd(5'd0, v); check("af_no_retrigger", v, 32'h0);
      check("af_irq_no_retrigger", 32'(irq), 32'h0);

      // Masked overflow on ch1
      csr_wr(5'd1, 32'h0);
      csr_rd(5'd1, v); check("irq_en_rb", v, 32'h0);
      for (int i = 0; i < 65; i++) push(1, 10'(i), 32'hE000_0000 + i);
      @(negedge clk);
      @(negedge clk);
      csr_rd(5'd0, v);  check("pend_ch1", v, 32'hA);
      check("irq_masked", 32'(irq), 32'h0);
      csr_rd(5'd17, v); check("status1_full", v, 32'hA000_0040 | DROP1);
      csr_wr(5'd1, 32'hF);
      @(negedge clk);
      check("irq_unmasked", 32'(irq), 32'h1);

      // Asynchronous reset during the read wait state
      avs_out_read    = 1'b1;
      avs_out_address = AW'(3);
      #2;
      check("pre_rst_wait", 32'(avs_out_waitrequest), 32'h1);
      reset_n = 1'b0;
      #1;
      check("mid_rst_wait", 32'(avs_out_waitrequest), 32'h1);
      check("mid_rst_irq", 32'(irq), 32'h0);
      check("mid_rst_empty", 32'(empty), 32'h3);
      csr_rd(5'd16, v); check("mid_rst_status0", v, 32'h4000_0000);
      csr_rd(5'd17, v); check("mid_rst_status1", v, 32'h4000_0000);
      csr_rd(5'd2, v);  check("mid_rst_thresh", v, 32'd56);
      csr_rd(5'd0, v);  check("mid_rst_pend", v, 32'h0);
      avs_out_read = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_channel_monitor_fifo.md
# multi_channel_monitor_fifo

Multi-channel successor to the single-queue monitor FIFO. It buffers (address, data) write records captured from NUM_CHANNELS independent monitored cores, each channel in its own FIFO. The queues are drained by the comparator/host through one Avalon-MM read slave. The block sits between the per-core capture ports and the NMR comparator, and adds per-channel almost-full and overflow interrupts with masking, a run-time threshold, and guaranteed no-write-when-full behaviour.

## Interface
- NUM_CHANNELS, 2: number of independent queues, 1..8.
- DATA_WIDTH, 32: captured data width.
- ADDRESS_WIDTH, 10: captured address width and read-slave address width; must be ≥ 1+CH_W.
- CSR_ADDRESS_WIDTH, 5: CSR address width.
- FIFO_DEPTH, 64: entries per channel; power of two, 4..256.
- ALMOST_FULL, 56: reset value of the threshold register.
- Derived: PTR_W = log2(FIFO_DEPTH); CNT_W = PTR_W+1; CH_W = max(1, log2ceil(NUM_CHANNELS)).

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- avs_in_write  in  NUM_CHANNELS  per-channel push strobe.
- avs_in_writedata  in  NUM_CHANNELS*DATA_WIDTH  packed; channel c at [c*DATA_WIDTH +: DATA_WIDTH].
- avs_in_address  in  NUM_CHANNELS*ADDRESS_WIDTH  packed captured address.
- avs_in_waitrequest  out  1  tied 0.
- avs_out_read  in  1  read strobe.
- avs_out_address  in  ADDRESS_WIDTH  [0]: 0 = address field, 1 = data field plus pop; [CH_W:1]: channel.
- avs_out_readdata  out  DATA_WIDTH  read data; address field is zero-extended.
- avs_out_waitrequest  out  reg 1  read wait state.
- empty  out  NUM_CHANNELS  per-channel empty, for the hardware comparator.
- irq  out  1  level interrupt.
- csr_address  in  CSR_ADDRESS_WIDTH
- csr_read, csr_write  in  1
- csr_writedata  in  DATA_WIDTH
- csr_readdata  out  DATA_WIDTH  combinational.

## Operation
- Each channel has a head pointer, a tail pointer, and a count of CNT_W bits. Pointers wrap from FIFO_DEPTH-1 to 0.
- full = (count == FIFO_DEPTH). empty = (count == 0). almost_full = (count ≥ threshold).
- A push on channel c is accepted when the channel is not full, or when a pop on c commits in the same cycle.
- A rejected push leaves memory and pointers unchanged and sets OVF_PEND[c].
- A pop commits only when all of these hold in the same cycle: avs_out_read, address[0] = 1, waitrequest = 0, and the channel is not empty.
- A push and a pop on the same channel in one cycle leave count unchanged. A pop on an empty channel is ignored, even when a push arrives that cycle.
- avs_out_readdata is 0 when the selected channel is empty, or when the channel index is ≥ NUM_CHANNELS.
- CSR map:
  - 0: IRQ_PEND, {OVF_PEND[N-1:0], AF_PEND[N-1:0]}, write-1-to-clear.
  - 1: IRQ_EN, same layout, read/write; resets to all ones.
  - 2: THRESH [CNT_W-1:0], read/write.
  - 16+c: STATUS[c] = {almost_full[31], empty[30], full[29], drop_cnt[27:16], count[CNT_W-1:0]}.
  - Unused addresses and bits read 0.
- AF_PEND[c] is set on the rising edge of almost_full[c].
- When a set and a W1C clear of the same pending bit occur in one cycle, the set wins.
- irq = |(IRQ_PEND & IRQ_EN), registered.

## Timing
- Push in cycle N: count, empty and full update at edge N+1; the entry is readable from cycle N+1.
- Read protocol:
  - avs_out_waitrequest resets to 1.
  - Read asserted in cycle N: waitrequest is 1 in N and 0 in N+1.
  - readdata is valid in N+1 and the pop commits at edge N+2.
  - waitrequest returns to 1 in N+2.
  - A continuously held read completes every second cycle.
- almost_full edge at edge N: AF_PEND is set at edge N+1 and irq rises at edge N+2.
- Asynchronous reset, including mid-read, clears in the same instant: pointers, counts, pending bits and drop counters to 0; THRESH to ALMOST_FULL; IRQ_EN to all ones; waitrequest to 1; irq to 0; empty to all ones.

## Configuration
- MONITOR_FIFO_DROP_CNT_EN defined: each channel has a 12-bit drop counter that increments on every rejected push and saturates at 4095. Writing any value to STATUS[c] clears it.
- MONITOR_FIFO_DROP_CNT_EN undefined: no drop counters; bits [27:16] read 0. OVF_PEND behaviour is unchanged.

## Test plan
- Push 3 records on ch0 and 2 on ch1, then pop all → FIFO order per channel; empty = 2'b11 afterwards; address reads on an empty channel return 0.
- Fill ch0 with 64 entries, push 3 more → count = 64, full = 1, OVF_PEND[0] = 1, irq = 1; with the macro, drop_cnt = 3; the first 64 records are intact.
- Full ch0 with a push and a pop in the same cycle → push accepted, count stays 64, no overflow flagged.
- Write THRESH = 4, push 4 entries → AF_PEND[0] sets once and irq rises 2 cycles after the 4th push edge; W1C 0x1 → irq falls; a 5th push causes no re-trigger.
- Write IRQ_EN = 0, overflow ch1 → pending bit set, irq stays 0; write IRQ_EN back → irq = 1.
- Assert reset_n low during the read wait state → waitrequest = 1, all counts 0, THRESH = 56 immediately.
